// File: rtl/audio_tone_ctrl_if.sv
// Decode-stage command strobes and speaker/status outputs of audio_tone_ctrl.
interface audio_tone_ctrl_if;
   logic       audio_en;
   logic [3:0] audio_sel;
   logic [4:0] audio_vol;
   logic       stop;
   logic       speaker_out;
   logic       busy;
   logic       fifo_full;
   logic       overflow;
   logic [3:0] cur_sel;

   modport master (output audio_en, audio_sel, audio_vol, stop,
                   input  speaker_out, busy, fifo_full, overflow, cur_sel);
   modport slave  (input  audio_en, audio_sel, audio_vol, stop,
                   output speaker_out, busy, fifo_full, overflow, cur_sel);
endinterface

// File: rtl/audio_tone_ctrl.sv
// Queues {sel,vol} tone commands and plays each as a timed, PWM-scaled square wave.
// Optional macro AUDIO_FADE_EN halves the volume over the last quarter of each note.
module audio_tone_ctrl #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned BASE_HALF   = 100,
   parameter int unsigned STEP        = 5,
   parameter int unsigned NOTE_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES  = 16
) (
   input  logic             clk,
   input  logic             reset,
   audio_tone_ctrl_if.slave bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned DW = $clog2(NOTE_CYCLES);
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
   typedef struct packed {
      logic [3:0] sel;
      logic [4:0] vol;
   } cmd_t;

   cmd_t          mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   state_t        state_q, state_d;
   logic [3:0]    sel_q, sel_d;
   logic [4:0]    vol_q, vol_d;
   logic [15:0]   half_cnt_q, half_cnt_d;
   logic          tone_q, tone_d;
   logic [4:0]    pwm_q, pwm_d;
   logic [DW-1:0] dur_q, dur_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          ovf_q, ovf_d;
   logic          spk_q, spk_d;

   logic          empty, full, push;
   logic [15:0]   half;
   logic [4:0]    vol_eff;

   // Extra pointer MSB tells full from empty once the pointers wrap.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = bus.audio_en && !full && !bus.stop;
   assign half  = 16'(BASE_HALF) - 16'(sel_q) * 16'(STEP);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      sel_d      = sel_q;
      vol_d      = vol_q;
      half_cnt_d = half_cnt_q;
      tone_d     = tone_q;
      pwm_d      = pwm_q;
      dur_d      = dur_q;
      gap_d      = gap_q;
      ovf_d      = ovf_q;
      vol_eff    = '0;
      spk_d      = 1'b0;

      if (push)
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (bus.audio_en && full && !bus.stop)
         ovf_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (!empty)
               state_d = S_LOAD;
         end
         S_LOAD: begin
            sel_d      = mem_q[rd_ptr_q[AW-1:0]].sel;
            vol_d      = mem_q[rd_ptr_q[AW-1:0]].vol;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            half_cnt_d = '0;
            tone_d     = 1'b0;
            pwm_d      = '0;
            dur_d      = '0;
            state_d    = S_PLAY;
         end
         S_PLAY: begin
            dur_d = dur_q + DW'(1);
            pwm_d = pwm_q + 5'd1;
            if (half_cnt_q == half - 16'd1) begin
               tone_d     = !tone_q;
               half_cnt_d = '0;
            end else begin
               half_cnt_d = half_cnt_q + 16'd1;
            end
            if (dur_q == DW'(NOTE_CYCLES - 1)) begin
               state_d = S_GAP;
               gap_d   = '0;
            end
         end
         S_GAP: begin
            gap_d = gap_q + GW'(1);
            if (gap_q == GW'(GAP_CYCLES - 1))
               state_d = empty ? S_IDLE : S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase

      // stop flushes the queue and the note; overflow survives until reset.
      if (bus.stop) begin
         state_d    = S_IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         sel_d      = '0;
         vol_d      = '0;
         half_cnt_d = '0;
         tone_d     = 1'b0;
         pwm_d      = '0;
         dur_d      = '0;
         gap_d      = '0;
      end

`ifdef AUDIO_FADE_EN
      vol_eff = (dur_d >= DW'(NOTE_CYCLES - NOTE_CYCLES/4)) ? (vol_d >> 1) : vol_d;
`else
      vol_eff = vol_d;
`endif
      // Built from next-state values so the registered output lines up with the counters.
      spk_d = (state_d == S_PLAY) && tone_d && (pwm_d < vol_eff) && (sel_d != 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sel_q      <= '0;
         vol_q      <= '0;
         half_cnt_q <= '0;
         tone_q     <= 1'b0;
         pwm_q      <= '0;
         dur_q      <= '0;
         gap_q      <= '0;
         ovf_q      <= 1'b0;
         spk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sel_q      <= sel_d;
         vol_q      <= vol_d;
         half_cnt_q <= half_cnt_d;
         tone_q     <= tone_d;
         pwm_q      <= pwm_d;
         dur_q      <= dur_d;
         gap_q      <= gap_d;
         ovf_q      <= ovf_d;
         spk_q      <= spk_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q[AW-1:0]] <= {bus.audio_sel, bus.audio_vol};
   end

   assign bus.speaker_out = spk_q;
   assign bus.busy        = (state_q != S_IDLE) || !empty;
   assign bus.fifo_full   = full;
   assign bus.overflow    = ovf_q;
   assign bus.cur_sel     = (state_q == S_PLAY) ? sel_q : 4'd0;
endmodule
